// File: rtl/key_expand_128.sv
// AES-128 key schedule: emits round keys 0..10 over valid/ready.
// SubWord uses four combinational S-box lookups on the rotated last word.

module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  logic [127:0] row;
  logic [6:0]   sh;

  // Each row packs 16 S-box entries; byte 0 sits in the top bits.
  function automatic logic [127:0] sbox_row(input logic [3:0] h);
    logic [127:0] r;
    r = '0;
    case (h)
      4'h0: r = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: r = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: r = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: r = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: r = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: r = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: r = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: r = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: r = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: r = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: r = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: r = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: r = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: r = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: r = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: r = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Row by high nibble, then byte by low nibble (15-lo == ~lo).
  always_comb begin
    row   = sbox_row(in_i[7:4]);
    sh    = {~in_i[3:0], 3'b000};
    out_o = row[sh +: 8];
  end

endmodule

module key_expand_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done
);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] key_q, key_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [127:0] next_key;

  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  sbox u_sb3 (.in_i(rot[31:24]), .out_o(sub[31:24]));
  sbox u_sb2 (.in_i(rot[23:16]), .out_o(sub[23:16]));
  sbox u_sb1 (.in_i(rot[15:8]),  .out_o(sub[15:8]));
  sbox u_sb0 (.in_i(rot[7:0]),   .out_o(sub[7:0]));

  // rcon for the key being produced, i.e. index idx_q+1.
  always_comb begin
    rcon = 8'h00;
    case (idx_q)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One full schedule step from the current key register.
  always_comb begin
    temp     = sub ^ {rcon, 24'h0};
    n0       = w0 ^ temp;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Next-state: load on start, advance on each accepted key.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          if (idx_q == 4'd10) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == S_EMIT);
  assign rk_valid  = (state_q == S_EMIT);
  assign rk_index  = idx_q;
  assign round_key = key_q;
  assign done      = done_q;

endmodule
